// File: rtl/client_tx.sv
// client_tx: AXI-Stream transmitter draining a local operand FIFO onto an AXIS master.
// Define CLIENT_TX_STORE_FWD_EN to start a packet only once all of it is buffered.
module client_tx #(
   parameter int DATAW      = 128,
   parameter int AXIS_DATAW = 512,
   parameter int FIFO_DEPTH = 16,
   parameter int CNTW       = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATAW-1:0]                client_tdata,
   input  logic                            client_tlast,
   input  logic                            client_valid,
   output logic                            client_ready,
   output logic                            axis_client_interface_tvalid,
   output logic                            axis_client_interface_tlast,
   output logic [AXIS_DATAW-1:0]           axis_client_interface_tdata,
   input  logic                            axis_client_interface_tready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic [CNTW-1:0]                 beats_sent,
   output logic [CNTW-1:0]                 packets_sent
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

   logic [DATAW:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ready_q;
   out_state_e       state_q;
   logic [DATAW-1:0] data_q;
   logic             last_q;
   logic [CNTW-1:0]  beats_q, packets_q;
   logic [DATAW:0]   head;
   logic             push, pop, handshake, load_ok;

   assign head      = mem_q[rd_ptr_q];
   assign push      = client_valid && ready_q;
   assign handshake = (state_q == OUT_FULL) && axis_client_interface_tready;
   assign pop       = (count_q != '0) && load_ok &&
                      ((state_q == OUT_EMPTY) || axis_client_interface_tready);

`ifdef CLIENT_TX_STORE_FWD_EN
   // Packets whose tlast is already buffered; a packet is only started once it is complete.
   logic [CW-1:0] pkts_q, pkts_d;

   assign load_ok = (pkts_q != '0);

   always_comb begin
      pkts_d = pkts_q;
      if (push && client_tlast) pkts_d = pkts_d + CW'(1);
      if (pop && head[DATAW])   pkts_d = pkts_d - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) pkts_q <= '0;
      else      pkts_q <= pkts_d;
   end
`else
   assign load_ok = 1'b1;
`endif

   // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {client_tlast, client_tdata};
   end

   // NOTE: combinational next-state gets a default for every output first, so no latch forms.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= (count_d < CW'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= OUT_EMPTY;
         data_q    <= '0;
         last_q    <= 1'b0;
         beats_q   <= '0;
         packets_q <= '0;
      end else begin
         if (handshake) begin
            beats_q <= beats_q + CNTW'(1);
            if (last_q) packets_q <= packets_q + CNTW'(1);
         end
         case (state_q)
            OUT_EMPTY: begin
               if (pop) begin
                  data_q  <= head[DATAW-1:0];
                  last_q  <= head[DATAW];
                  state_q <= OUT_FULL;
               end
            end
            OUT_FULL: begin
               if (handshake) begin
                  if (pop) begin
                     data_q <= head[DATAW-1:0];
                     last_q <= head[DATAW];
                  end else begin
                     state_q <= OUT_EMPTY;
                  end
               end
            end
            default: state_q <= OUT_EMPTY;
         endcase
      end
   end

   assign client_ready                 = ready_q;
   assign axis_client_interface_tvalid = (state_q == OUT_FULL);
   assign axis_client_interface_tlast  = last_q;
   assign fifo_count                   = count_q;
   assign beats_sent                   = beats_q;
   assign packets_sent                 = packets_q;

   generate
      if (AXIS_DATAW > DATAW) begin : g_pad
         assign axis_client_interface_tdata = {{(AXIS_DATAW-DATAW){1'b0}}, data_q};
      end else begin : g_nopad
         assign axis_client_interface_tdata = data_q;
      end
   endgenerate

endmodule

// File: tb/tb_client_tx.sv
// Directed bench for client_tx: reset, pipeline, backpressure, full FIFO, reset mid-packet.
module tb_client_tx;
   localparam int DATAW      = 128;
   localparam int AXIS_DATAW = 512;
   localparam int FIFO_DEPTH = 16;
   localparam int CNTW       = 16;
`ifdef CLIENT_TX_STORE_FWD_EN
   localparam bit LAST5 = 1'b1;
`else
   localparam bit LAST5 = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [DATAW-1:0]      client_tdata;
   logic                  client_tlast;
   logic                  client_valid;
   logic                  client_ready;
   logic                  tvalid, tlast, tready;
   logic [AXIS_DATAW-1:0] tdata;
   logic [4:0]            fifo_count;
   logic [CNTW-1:0]       beats_sent, packets_sent;

   int passed = 0, failed = 0, total = 0;
   int exp_beats = 0, exp_pkts = 0;

   client_tx #(
      .DATAW(DATAW), .AXIS_DATAW(AXIS_DATAW), .FIFO_DEPTH(FIFO_DEPTH), .CNTW(CNTW)
   ) dut (
      .clk                          (clk),
      .rst                          (rst),
      .client_tdata                 (client_tdata),
      .client_tlast                 (client_tlast),
      .client_valid                 (client_valid),
      .client_ready                 (client_ready),
      .axis_client_interface_tvalid (tvalid),
      .axis_client_interface_tlast  (tlast),
      .axis_client_interface_tdata  (tdata),
      .axis_client_interface_tready (tready),
      .fifo_count                   (fifo_count),
      .beats_sent                   (beats_sent),
      .packets_sent                 (packets_sent)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand and return just after the edge that accepted it.
   task automatic push(input logic [DATAW-1:0] d, input logic l);
      int n = 0;
      client_valid = 1'b1;
      client_tdata = d;
      client_tlast = l;
      while (!client_ready && n < 200) begin
         tick();
         n++;
      end
      check("push_ready", client_ready, 1'b1);
      tick();
      client_valid = 1'b0;
   endtask

   // Wait up to max_wait cycles for tvalid, check the beat, then let it handshake (tready=1).
   task automatic expect_beat(input logic [DATAW-1:0] d, input logic l, input int max_wait);
      int n = 0;
      while (!tvalid && n < max_wait) begin
         tick();
         n++;
      end
      check("beat_valid", tvalid, 1'b1);
      check("beat_data", tdata, d);
      check("beat_last", tlast, l);
      exp_beats++;
      if (l) exp_pkts++;
      tick();
   endtask

   initial begin
      int sum = 0;
      int valid_cycles = 0;
      logic moved = 1'b0;

      rst          = 1'b0;
      client_valid = 1'b1;
      client_tdata = 'hAA;
      client_tlast = 1'b0;
      tready       = 1'b0;

      // Reset held for three edges while the producer is offering data
      repeat (3) tick();
      check("rst_tvalid", tvalid, 1'b0);
      check("rst_tlast", tlast, 1'b0);
      check("rst_tdata", tdata, 0);
      check("rst_ready", client_ready, 1'b0);
      check("rst_count", fifo_count, 0);
      check("rst_beats", beats_sent, 0);
      check("rst_pkts", packets_sent, 0);
      rst          = 1'b1;
      client_valid = 1'b0;
      tick();
      check("rel_ready", client_ready, 1'b1);
      check("rel_tvalid", tvalid, 1'b0);
      check("rel_count", fifo_count, 0);

`ifdef CLIENT_TX_STORE_FWD_EN
      // Partial packet is held back until its tlast arrives
      tready = 1'b1;
      push('h400, 1'b0);
      push('h401, 1'b0);
      push('h402, 1'b0);
      tick();
      tick();
      check("sf_hold_tvalid", tvalid, 1'b0);
      check("sf_hold_count", fifo_count, 3);
      push('h403, 1'b1);
      expect_beat('h400, 1'b0, 3);
      expect_beat('h401, 1'b0, 0);
      expect_beat('h402, 1'b0, 0);
      expect_beat('h403, 1'b1, 0);
      check("sf_done_tvalid", tvalid, 1'b0);
`else
      // Cut-through: 1,2,3 pushed on consecutive edges, sink always ready
      tready       = 1'b1;
      client_valid = 1'b1;
      client_tdata = 1;
      client_tlast = 1'b0;
      tick();
      check("ct_lat_tvalid", tvalid, 1'b0);
      client_tdata = 2;
      tick();
      check("ct_b1_valid", tvalid, 1'b1);
      check("ct_b1_data", tdata, 1);
      check("ct_b1_last", tlast, 1'b0);
      sum += int'(tdata[31:0]);
      client_tdata = 3;
      client_tlast = 1'b1;
      tick();
      check("ct_b2_valid", tvalid, 1'b1);
      check("ct_b2_data", tdata, 2);
      check("ct_b2_last", tlast, 1'b0);
      check("ct_b2_beats", beats_sent, 1);
      sum += int'(tdata[31:0]);
      client_valid = 1'b0;
      client_tlast = 1'b0;
      tick();
      check("ct_b3_valid", tvalid, 1'b1);
      check("ct_b3_data", tdata, 3);
      check("ct_b3_last", tlast, 1'b1);
      sum += int'(tdata[31:0]);
      tick();
      check("ct_end_tvalid", tvalid, 1'b0);
      check("ct_sum", sum, 6);
      exp_beats = 3;
      exp_pkts  = 1;
`endif
      check("p1_beats", beats_sent, exp_beats);
      check("p1_pkts", packets_sent, exp_pkts);

      // Backpressure: first beat must stay stable for 10 stalled cycles
      tready = 1'b0;
      push('h11, 1'b0);
      push('h12, 1'b0);
      push('h13, 1'b0);
      push('h14, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tvalid) valid_cycles++;
         if (tvalid && tdata[DATAW-1:0] != 'h11) moved = 1'b1;
      end
      check("bp_stable", moved, 1'b0);
      check("bp_valid_cycles", valid_cycles, 10);
      check("bp_data", tdata, 'h11);
      check("bp_count", fifo_count, 3);
      tready = 1'b1;
      expect_beat('h11, 1'b0, 0);
      expect_beat('h12, 1'b0, 0);
      expect_beat('h13, 1'b0, 0);
      expect_beat('h14, 1'b1, 0);
      check("bp_end_tvalid", tvalid, 1'b0);
      check("bp_beats", beats_sent, exp_beats);
      check("bp_pkts", packets_sent, exp_pkts);

      // Full: output register takes the first operand, FIFO takes 16 more, the 18th waits
      tready = 1'b0;
      for (int i = 0; i < 17; i++) push(DATAW'('h100 + i), 1'b1);
      check("full_count", fifo_count, 16);
      check("full_ready", client_ready, 1'b0);
      check("full_data", tdata, 'h100);
      client_valid = 1'b1;
      client_tdata = 'h111;
      client_tlast = 1'b1;
      repeat (3) tick();
      check("full_hold_count", fifo_count, 16);
      check("full_hold_ready", client_ready, 1'b0);
      tready = 1'b1;
      expect_beat('h100, 1'b1, 0);
      tready = 1'b0;
      check("full_pop_ready", client_ready, 1'b1);
      check("full_pop_count", fifo_count, 15);
      tick();
      client_valid = 1'b0;
      check("full_refill_count", fifo_count, 16);
      check("full_refill_ready", client_ready, 1'b0);
      tready = 1'b1;
      for (int i = 1; i < 18; i++) expect_beat(DATAW'('h100 + i), 1'b1, 0);
      check("full_end_tvalid", tvalid, 1'b0);
      check("full_end_count", fifo_count, 0);
      check("full_beats", beats_sent, exp_beats);
      check("full_pkts", packets_sent, exp_pkts);

      // Reset in the middle of a packet after two handshakes
      tready = 1'b0;
      push('h200, 1'b0);
      push('h201, 1'b0);
      push('h202, 1'b0);
      push('h203, 1'b0);
      push('h204, LAST5);
      tready = 1'b1;
      expect_beat('h200, 1'b0, 3);
      expect_beat('h201, 1'b0, 0);
      rst = 1'b0;
      tick();
      exp_beats = 0;
      exp_pkts  = 0;
      check("mid_rst_tvalid", tvalid, 1'b0);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_beats", beats_sent, 0);
      check("mid_rst_pkts", packets_sent, 0);
      check("mid_rst_ready", client_ready, 1'b0);
      check("mid_rst_tdata", tdata, 0);
      rst = 1'b1;
      tick();
      check("mid_rel_ready", client_ready, 1'b1);
      check("mid_rel_tvalid", tvalid, 1'b0);
      push('h300, 1'b1);
      expect_beat('h300, 1'b1, 3);
      check("post_rst_tvalid", tvalid, 1'b0);
      check("post_rst_beats", beats_sent, exp_beats);
      check("post_rst_pkts", packets_sent, exp_pkts);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
